// File: rtl/video_capture.sv
// video_capture: samples a pixel-clock RGB/sync/blank stream, recovers x/y and
// frame geometry, tracks geometry lock and queues active pixels in a show-ahead FIFO.
// Ports: pixel_clock/reset_n; vid_* video in; px_* valid/ready pixel out;
// frame_start, line_width, frame_height, locked, overflow status.
module video_capture #(
    parameter int XW         = 11,
    parameter int YW         = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          pixel_clock,
    input  logic          reset_n,
    input  logic [7:0]    vid_red,
    input  logic [7:0]    vid_green,
    input  logic [7:0]    vid_blue,
    input  logic          vid_hsync,
    input  logic          vid_vsync,
    input  logic          vid_blank,
    output logic          px_valid,
    input  logic          px_ready,
    output logic [23:0]   px_rgb,
    output logic [XW-1:0] px_x,
    output logic [YW-1:0] px_y,
    output logic          frame_start,
    output logic [XW-1:0] line_width,
    output logic [YW-1:0] frame_height,
    output logic          locked,
    output logic          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = 24 + XW + YW;

    typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} lock_t;

    logic [23:0]   s1_rgb;
    logic          s1_hsync, s1_vsync, s1_blank;
    logic          s2_hsync, s2_vsync, s2_blank;
    logic          vs_fall, act_start, act_end;
    logic [XW-1:0] x_cnt, x_pix, x_nxt, first_w;
    logic [YW-1:0] row, row_inc, row_eff;
    logic          width_ok, first_seen, w_bad, good;
    lock_t         state_q, state_d;
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, push, pop, wr_en;
    logic [DW-1:0] head;
    logic          unused_hsync;

    // hsync is carried through the input stage but geometry comes from blank
    assign unused_hsync = s2_hsync;

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_rgb   <= '0;
            s1_hsync <= 1'b1;
            s1_vsync <= 1'b1;
            s1_blank <= 1'b1;
            s2_hsync <= 1'b1;
            s2_vsync <= 1'b1;
            s2_blank <= 1'b1;
        end else begin
            s1_rgb   <= {vid_red, vid_green, vid_blue};
            s1_hsync <= vid_hsync;
            s1_vsync <= vid_vsync;
            s1_blank <= vid_blank;
            s2_hsync <= s1_hsync;
            s2_vsync <= s1_vsync;
            s2_blank <= s1_blank;
        end
    end

    assign vs_fall   = s2_vsync & ~s1_vsync;
    assign act_start = s2_blank & ~s1_blank;
    assign act_end   = ~s2_blank & s1_blank;

    assign x_pix   = act_start ? '0 : x_cnt;
    assign x_nxt   = (&x_pix) ? x_pix : x_pix + XW'(1);
    assign row_inc = (&row) ? row : row + YW'(1);
    // a line ending in the vs_fall cycle still belongs to the closing frame
    assign row_eff = act_end ? row_inc : row;
    assign w_bad   = act_end & first_seen & (x_cnt != first_w);
    assign good    = width_ok & ~w_bad & (row_eff != '0)
                   & (row_eff == frame_height);

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt        <= '0;
            row          <= '0;
            line_width   <= '0;
            frame_height <= '0;
            frame_start  <= 1'b0;
            width_ok     <= 1'b0;
            first_seen   <= 1'b0;
            first_w      <= '0;
        end else begin
            frame_start <= vs_fall;
            if (!s1_blank)
                x_cnt <= x_nxt;
            if (act_end)
                line_width <= x_cnt;
            if (vs_fall) begin
                row          <= '0;
                frame_height <= row_eff;
                width_ok     <= 1'b1;
                first_seen   <= 1'b0;
            end else begin
                if (act_end)
                    row <= row_inc;
                if (w_bad)
                    width_ok <= 1'b0;
                if (act_end && !first_seen) begin
                    first_seen <= 1'b1;
                    first_w    <= x_cnt;
                end
            end
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n)
            state_q <= UNLOCKED;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (vs_fall) begin
            unique case (state_q)
                UNLOCKED: state_d = good ? CHECK : UNLOCKED;
                CHECK:    state_d = good ? LOCKED : UNLOCKED;
                LOCKED:   state_d = good ? LOCKED : UNLOCKED;
                default:  state_d = UNLOCKED;
            endcase
        end
    end

    assign locked = (state_q == LOCKED);

    assign full  = (wr_ptr[AW] != rd_ptr[AW])
                 && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign px_valid = (wr_ptr != rd_ptr);
    assign push  = ~s1_blank;
    assign pop   = px_valid & px_ready;
    // a full FIFO still accepts when the head leaves in the same cycle
    assign wr_en = push & (~full | pop);

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= {s1_rgb, x_pix, row};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    assign head   = mem[rd_ptr[AW-1:0]];
    assign px_rgb = head[DW-1 -: 24];
    assign px_x   = head[XW+YW-1 : YW];
    assign px_y   = head[YW-1:0];

endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: directed vector table plus hand-written sequences for
// video_capture (line timing, geometry lock, backpressure, full push/pop).
module tb_video_capture;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  vid_red, vid_green, vid_blue;
    logic        vid_hsync, vid_vsync, vid_blank;
    logic        px_valid, px_ready;
    logic [23:0] px_rgb;
    logic [10:0] px_x;
    logic [9:0]  px_y;
    logic        frame_start;
    logic [10:0] line_width;
    logic [9:0]  frame_height;
    logic        locked, overflow;

    int n_vec = 0;
    int n_bad = 0;
    int fs_cnt = 0;

    typedef struct {
        logic [23:0] rgb;
        logic [10:0] x;
        logic [9:0]  y;
    } pop_t;
    pop_t popq[$];

    typedef struct {
        logic        blank;
        logic [23:0] rgb;
        logic        ev;
        logic [10:0] ex;
        logic [23:0] ergb;
        logic [10:0] elw;
    } vec_t;
    vec_t tv[12];

    always #5 clk = ~clk;

    video_capture #(.XW(11), .YW(10), .FIFO_DEPTH(4)) dut (
        .pixel_clock (clk),
        .reset_n     (reset_n),
        .vid_red     (vid_red),
        .vid_green   (vid_green),
        .vid_blue    (vid_blue),
        .vid_hsync   (vid_hsync),
        .vid_vsync   (vid_vsync),
        .vid_blank   (vid_blank),
        .px_valid    (px_valid),
        .px_ready    (px_ready),
        .px_rgb      (px_rgb),
        .px_x        (px_x),
        .px_y        (px_y),
        .frame_start (frame_start),
        .line_width  (line_width),
        .frame_height(frame_height),
        .locked      (locked),
        .overflow    (overflow)
    );

    always @(negedge clk) begin
        if (frame_start)
            fs_cnt++;
        if (reset_n && px_valid && px_ready)
            popq.push_back('{rgb: px_rgb, x: px_x, y: px_y});
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic bl, input logic vs, input logic [23:0] c);
        vid_blank = bl;
        vid_vsync = vs;
        {vid_red, vid_green, vid_blue} = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_line(input int n);
        for (int k = 0; k < n; k++)
            step(1'b0, 1'b1, 24'h400000 + 24'(k));
        for (int k = 0; k < 4; k++)
            step(1'b1, 1'b1, 24'h0);
    endtask

    task automatic vpulse();
        step(1'b1, 1'b0, 24'h0);
        step(1'b1, 1'b0, 24'h0);
        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b1, 24'h0);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        vid_blank = 1'b1;
        vid_vsync = 1'b1;
        vid_hsync = 1'b1;
        {vid_red, vid_green, vid_blue} = 24'h0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        step(1'b1, 1'b1, 24'h0);
        step(1'b1, 1'b1, 24'h0);
    endtask

    initial begin
        int fs0;
        logic bad;

        // reset held while the inputs are busy
        reset_n   = 1'b0;
        px_ready  = 1'b1;
        vid_hsync = 1'b1;
        for (int k = 0; k < 6; k++) begin
            vid_blank = k[0];
            vid_vsync = 1'b0;
            vid_hsync = k[1];
            {vid_red, vid_green, vid_blue} = 24'hABCDEF + 24'(k);
            @(posedge clk);
            #1;
        end
        chk("rst_valid", 32'(px_valid), 0);
        chk("rst_rgb", 32'(px_rgb), 0);
        chk("rst_x", 32'(px_x), 0);
        chk("rst_y", 32'(px_y), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_lw", 32'(line_width), 0);
        chk("rst_fh", 32'(frame_height), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_ovf", 32'(overflow), 0);
        vid_blank = 1'b1;
        vid_vsync = 1'b1;
        vid_hsync = 1'b1;
        #2;
        fs0 = fs_cnt;
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++)
            step(1'b1, 1'b1, 24'h0);
        chk("rst_no_fs", 32'(fs_cnt - fs0), 0);

        // single 8-pixel line, vector e applied before edge e
        for (int e = 0; e < 12; e++) begin
            tv[e].blank = !(e >= 1 && e <= 8);
            tv[e].rgb   = tv[e].blank ? 24'h0 : 24'h112233 + 24'(e - 1);
            tv[e].ev    = (e >= 2 && e <= 9);
            tv[e].ex    = 11'(e - 2);
            tv[e].ergb  = 24'h112233 + 24'(e - 2);
            tv[e].elw   = (e >= 10) ? 11'd8 : 11'd0;
        end
        px_ready = 1'b1;
        for (int e = 0; e < 12; e++) begin
            step(tv[e].blank, 1'b1, tv[e].rgb);
            n_vec++;
            bad = (px_valid !== tv[e].ev) || (line_width !== tv[e].elw)
               || (frame_start !== 1'b0);
            if (tv[e].ev)
                bad = bad || (px_x !== tv[e].ex) || (px_y !== 10'd0)
                   || (px_rgb !== tv[e].ergb);
            if (bad) begin
                n_bad++;
                $display("FAIL vec%0d: valid=%0b x=%0d y=%0d rgb=%h lw=%0d want valid=%0b x=%0d y=0 rgb=%h lw=%0d",
                         e, px_valid, px_x, px_y, px_rgb, line_width,
                         tv[e].ev, tv[e].ex, tv[e].ergb, tv[e].elw);
            end
        end

        // frame geometry and lock
        do_reset();
        for (int f = 0; f < 3; f++) begin
            fs0 = fs_cnt;
            for (int l = 0; l < 4; l++)
                do_line(16);
            vpulse();
            chk($sformatf("geo_fh%0d", f), 32'(frame_height), 4);
            chk($sformatf("geo_lock%0d", f), 32'(locked), (f == 2) ? 1 : 0);
            chk($sformatf("geo_fs%0d", f), 32'(fs_cnt - fs0), 1);
        end
        do_line(16);
        do_line(16);
        do_line(16);
        do_line(15);
        chk("geo_lw15", 32'(line_width), 15);
        chk("geo_still_lock", 32'(locked), 1);
        vpulse();
        chk("geo_unlock", 32'(locked), 0);
        chk("geo_fh4", 32'(frame_height), 4);
        chk("geo_ovf", 32'(overflow), 0);

        // backpressure with drops
        do_reset();
        px_ready = 1'b0;
        popq.delete();
        for (int k = 0; k < 6; k++)
            step(1'b0, 1'b1, 24'hA00000 + 24'(k));
        for (int k = 0; k < 4; k++)
            step(1'b1, 1'b1, 24'h0);
        chk("bp_valid", 32'(px_valid), 1);
        chk("bp_head_x", 32'(px_x), 0);
        chk("bp_head_rgb", 32'(px_rgb), 32'h00A00000);
        chk("bp_ovf", 32'(overflow), 1);
        px_ready = 1'b1;
        for (int k = 0; k < 8; k++)
            step(1'b1, 1'b1, 24'h0);
        chk("bp_pops", popq.size(), 4);
        for (int i = 0; i < popq.size() && i < 4; i++)
            chk($sformatf("bp_x%0d", i), 32'(popq[i].x), i);
        chk("bp_empty", 32'(px_valid), 0);
        chk("bp_ovf_sticky", 32'(overflow), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_ovf", 32'(overflow), 0);
        chk("async_rst_lw", 32'(line_width), 0);

        // full FIFO with same-cycle push and pop
        do_reset();
        px_ready = 1'b0;
        popq.delete();
        for (int k = 0; k < 20; k++) begin
            if (k == 5)
                px_ready = 1'b1;
            step(1'b0, 1'b1, 24'hC00000 + 24'(k));
        end
        for (int k = 0; k < 8; k++)
            step(1'b1, 1'b1, 24'h0);
        chk("full_pops", popq.size(), 20);
        bad = 1'b0;
        for (int i = 0; i < popq.size(); i++)
            if (popq[i].x !== 11'(i) || popq[i].rgb !== 24'hC00000 + 24'(i))
                bad = 1'b1;
        chk("full_seq", 32'(bad), 0);
        chk("full_ovf", 32'(overflow), 0);

        // vs_fall in the same cycle as act_end
        do_reset();
        px_ready = 1'b1;
        fs0 = fs_cnt;
        for (int l = 0; l < 3; l++)
            do_line(16);
        for (int k = 0; k < 16; k++)
            step(1'b0, 1'b1, 24'h500000 + 24'(k));
        step(1'b1, 1'b0, 24'h0);
        step(1'b1, 1'b0, 24'h0);
        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b1, 24'h0);
        chk("co_fh", 32'(frame_height), 4);
        chk("co_lw", 32'(line_width), 16);
        chk("co_fs", 32'(fs_cnt - fs0), 1);
        popq.delete();
        do_line(8);
        chk("co_pops", popq.size(), 8);
        if (popq.size() > 0) begin
            chk("co_y0", 32'(popq[0].y), 0);
            chk("co_x0", 32'(popq[0].x), 0);
        end
        do_line(16);
        do_line(16);
        do_line(16);
        vpulse();
        chk("co_fh_next", 32'(frame_height), 4);
        chk("co_lw_next", 32'(line_width), 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/video_capture.md
# video_capture

Receive-side counterpart of the registered VGA output stage: samples a pixel-clock-synchronous RGB/hsync/vsync/blank stream, recovers per-pixel (x, y) coordinates and frame geometry, and hands active pixels to a downstream consumer through a small FIFO with a valid/ready handshake. It sits between any video source in the design (the MC6847 output path, or a loopback of it) and frame-buffer writers or test monitors.

## Interface

Parameters:
- XW, 11, width of x coordinate and line_width
- YW, 10, width of y coordinate and frame_height
- FIFO_DEPTH, 4, pixel FIFO entries; power of two, at least 2

Ports:
- pixel_clock  input  1  sole clock; every register is on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- vid_red / vid_green / vid_blue  input  8 each  pixel colour
- vid_hsync  input  1  horizontal sync, active low (idle 1)
- vid_vsync  input  1  vertical sync, active low (idle 1)
- vid_blank  input  1  1 = blanking, 0 = active pixel
- px_valid  output  1  FIFO head holds a pixel
- px_ready  input  1  consumer accepts head when px_valid=1
- px_rgb  output  24  {red, green, blue} of head pixel
- px_x  output  XW  head pixel column
- px_y  output  YW  head pixel row
- frame_start  output  1  one-cycle pulse on vsync falling edge
- line_width  output  XW  active pixels in last completed line
- frame_height  output  YW  active lines in last completed frame
- locked  output  1  geometry stable
- overflow  output  1  sticky: a pixel was dropped

## Operation

- Input stage: all vid_* registered once (s1_*); a second copy of the sync and blank bits (s2_*) feeds edge detection. Reset loads s1/s2 syncs = 1, blank = 1, colour = 0.
- Edges: vs_fall = s2_vsync & ~s1_vsync; act_start = s2_blank & ~s1_blank; act_end = ~s2_blank & s1_blank.
- x counter: 0 on act_start; +1 after each active pixel (s1_blank=0); saturates at 2^XW-1.
- row counter: 0 on vs_fall; +1 on act_end; saturates at 2^YW-1. Active pixels carry the current row.
- On act_end: line_width <= x count of the run just finished.
- On vs_fall: frame_height <= row counter (value before clear); frame_start pulses. vs_fall and act_end in the same cycle: act_end applies first (row incremented, then captured), row then clears.
- Lock FSM, states UNLOCKED, CHECK, LOCKED. Per-frame flag width_ok: set on vs_fall; cleared on any act_end whose width differs from the first line of the frame. At each vs_fall, frame "good" = width_ok & row≠0 & row equals previous frame_height.
  - UNLOCKED: good -> CHECK.
  - CHECK: good -> LOCKED; not good -> UNLOCKED.
  - LOCKED: not good -> UNLOCKED.
  - locked = (state == LOCKED).
- FIFO: each active s1 pixel pushes {rgb, x, row}. Pop when px_valid & px_ready. Full and push without pop: pixel dropped, overflow <= 1 (cleared only by reset_n). Full with push and pop in the same cycle: both occur, no drop. Empty with push and pop: not possible (px_valid=0).
- Show-ahead output: px_rgb/px_x/px_y valid whenever px_valid=1; held stable until popped.

## Timing

- Reset (reset_n=0, asynchronous): px_valid=0, px_rgb=0, px_x=0, px_y=0, frame_start=0, line_width=0, frame_height=0, locked=0 (UNLOCKED), overflow=0, FIFO empty, counters 0.
- Pixel presented before edge k is in s1 after edge k, written to FIFO at edge k+1; px_valid is high after edge k+1 if the FIFO was empty (2-cycle latency).
- frame_start high for the single cycle after the edge at which vs_fall is registered (vsync low sampled at edge k -> pulse after edge k+1).
- line_width/frame_height update after the edge that registers act_end/vs_fall.
- Reset mid-frame: all state cleared; first frame after release treated as arbitrary, lock needs two further good frames.

## Test plan

- Reset: hold reset_n=0 with activity on inputs -> all outputs 0, px_valid=0; release -> no spurious frame_start.
- Single line: blank low for 8 cycles with rgb=0x112233..., px_ready=1 -> 8 pixels with px_x 0..7, px_y 0, correct rgb, first px_valid 2 cycles after first active sample; line_width=8 after act_end.
- Frame geometry: 3 frames of 4 lines x 16 pixels -> frame_height=4 at each vs_fall, locked=1 after third vs_fall; then a 15-pixel line -> locked=0 at next vs_fall.
- Backpressure: FIFO_DEPTH=4, px_ready=0, 6 active pixels -> pixels 0..3 held, overflow=1 and stays 1; px_ready=1 -> exactly 4 pops, x=0..3.
- Full with simultaneous push/pop: FIFO full, px_ready=1 during continuous active pixels -> no drop, overflow stays 0, x sequence contiguous.
- vs_fall coincident with act_end after line 3 -> frame_height=4, row restarts at 0 for next frame.
